// File: rtl/serial_parallel_aligner.sv
// serial_parallel_aligner: comma-aligned serial-to-parallel deserializer with lock and loss-of-sync detection
// clk_32f   : serial bit clock
// reset     : synchronous active-high reset
// data_in   : serial bit, MSB-first
// data_out  : last aligned word, held between boundaries
// valid_out : data_out is a non-comma word received while locked
// word_stb  : one-cycle pulse when data_out/valid_out update
// active    : high while locked
// sync_lost : one-cycle pulse when the comma gap forces a return to hunt
module serial_parallel_aligner #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] COMMA = 8'hBC,
  parameter int LOCK_COUNT = 4,
  parameter int MAX_GAP = 16
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             word_stb,
  output logic             active,
  output logic             sync_lost
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam int CC_W = $clog2(LOCK_COUNT + 1);
  localparam int GAP_W = MAX_GAP > 0 ? $clog2(MAX_GAP + 1) : 1;
  typedef enum logic [1:0] {HUNT, ALIGNING, LOCKED} state_t;
  state_t state_q, state_d;
  logic [WIDTH-2:0] sr_q;
  logic [WIDTH-1:0] w, data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CC_W-1:0] cc_q, cc_d, cc_inc;
  logic [GAP_W-1:0] gap_q, gap_d, gap_inc;
  logic valid_q, valid_d, stb_q, stb_d, lost_q, lost_d, active_q;
  logic comma, bnd;
  assign w = {sr_q, data_in};
  assign comma = w == COMMA;
  assign bnd = cnt_q == CNT_W'(WIDTH - 1);
  assign cc_inc = cc_q + 1'b1;
  // with loss detection disabled the gap counter simply never moves
  assign gap_inc = MAX_GAP == 0 ? '0 : gap_q + 1'b1;
  always_comb begin
    state_d = state_q;
    cnt_d = bnd ? '0 : cnt_q + 1'b1;
    cc_d = cc_q;
    gap_d = gap_q;
    data_d = data_q;
    valid_d = state_q == LOCKED && valid_q;
    stb_d = 1'b0;
    lost_d = 1'b0;
    if (state_q == HUNT) begin
      if (comma) begin
        cnt_d = '0;
        cc_d = CC_W'(1);
        gap_d = '0;
        state_d = LOCK_COUNT == 1 ? LOCKED : ALIGNING;
      end
    end else if (state_q == ALIGNING) begin
      if (bnd) begin
        cc_d = comma ? cc_inc : '0;
        gap_d = '0;
        state_d = !comma ? HUNT : cc_inc == CC_W'(LOCK_COUNT) ? LOCKED : ALIGNING;
      end
    end else if (bnd) begin
      data_d = w;
      valid_d = !comma;
      stb_d = 1'b1;
      gap_d = comma ? '0 : gap_inc;
      lost_d = MAX_GAP != 0 && !comma && gap_inc == GAP_W'(MAX_GAP);
      state_d = lost_d ? HUNT : LOCKED;
    end
  end
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q <= HUNT;
      sr_q <= '0;
      cnt_q <= '0;
      cc_q <= '0;
      gap_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      stb_q <= 1'b0;
      lost_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= w[WIDTH-2:0];
      cnt_q <= cnt_d;
      cc_q <= cc_d;
      gap_q <= gap_d;
      data_q <= data_d;
      valid_q <= valid_d;
      stb_q <= stb_d;
      lost_q <= lost_d;
      active_q <= state_d == LOCKED;
    end
  end
  assign data_out = data_q;
  assign valid_out = valid_q;
  assign word_stb = stb_q;
  assign active = active_q;
  assign sync_lost = lost_q;
endmodule
